// File: rtl/datapath.sv
// rtl/datapath.sv - K&S processor datapath: PC, IR, 4x16 register file, ALU and flags
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   branch, pc_enable, ir_enable  PC / IR load strobes from control_unit
//   write_reg_enable, c_sel       register write strobe and write-data select (1: ALU, 0: RAM)
//   addr_sel                      RAM address select (1: IR[4:0], 0: PC)
//   operation                     ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   flags_reg_enable              flag register capture strobe
//   data_in                       RAM read data
//   ram_addr, data_out            RAM address and write data
//   decoded_instruction           decode of IR[15:8]
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow               registered ALU flags

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_HALT, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV
  } decoded_instruction_type;
endpackage

module datapath
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  input  logic [DATA_W-1:0]       data_in,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow
);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] regs [4];

  logic [1:0]        a_sel, b_sel, wr_dest;
  logic              b_zero, wr_ok;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [DATA_W:0]   alu_wide;
  logic              alu_carry, alu_sovf;

  // IR[7] is not part of any instruction field.
  logic unused_ir_bit;
  assign unused_ir_bit = ir[7];

  always_comb begin
    decoded_instruction = I_NOP;
    case (ir[15:8])
      8'h00: decoded_instruction = I_NOP;
      8'hFF: decoded_instruction = I_HALT;
      8'h81: decoded_instruction = I_LOAD;
      8'h82: decoded_instruction = I_STORE;
      8'h91: decoded_instruction = I_MOVE;
      8'hA1: decoded_instruction = I_ADD;
      8'hA2: decoded_instruction = I_SUB;
      8'hA3: decoded_instruction = I_AND;
      8'hA4: decoded_instruction = I_OR;
      8'h01: decoded_instruction = I_BRANCH;
      8'h02: decoded_instruction = I_BZERO;
      8'h03: decoded_instruction = I_BNZERO;
      8'h04: decoded_instruction = I_BNEG;
      8'h05: decoded_instruction = I_BNNEG;
      8'h06: decoded_instruction = I_BOV;
      8'h07: decoded_instruction = I_BNOV;
      default: decoded_instruction = I_NOP;
    endcase
  end

  // Operand and destination selection depends on the instruction format.
  always_comb begin
    a_sel   = ir[3:2];
    b_sel   = ir[1:0];
    b_zero  = 1'b0;
    wr_dest = ir[5:4];
    wr_ok   = 1'b0;
    case (decoded_instruction)
      I_LOAD: begin
        wr_dest = ir[6:5];
        wr_ok   = 1'b1;
      end
      I_MOVE: begin
        a_sel   = ir[1:0];
        b_zero  = 1'b1;
        wr_dest = ir[3:2];
        wr_ok   = 1'b1;
      end
      I_ADD, I_SUB, I_AND, I_OR: wr_ok = 1'b1;
      default: wr_ok = 1'b0;
    endcase
  end

  assign alu_a = regs[a_sel];
  assign alu_b = b_zero ? '0 : regs[b_sel];

  always_comb begin
    alu_wide  = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_sovf  = 1'b0;
    case (operation)
      2'b00: alu_res = alu_a | alu_b;
      2'b01: begin
        alu_wide  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
        alu_sovf  = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                    (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
      end
      2'b10: begin
        // Bit DATA_W of the widened difference is the borrow.
        alu_wide  = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res   = alu_wide[DATA_W-1:0];
        alu_carry = alu_wide[DATA_W];
        alu_sovf  = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                    (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
      end
      default: alu_res = alu_a & alu_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc                <= '0;
      ir                <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
    end else begin
      if (pc_enable) pc <= branch ? ir[ADDR_W-1:0] : pc + 1'b1;
      if (ir_enable) ir <= data_in;
      if (write_reg_enable && wr_ok) regs[wr_dest] <= c_sel ? alu_res : data_in;
      if (flags_reg_enable) begin
        zero_op           <= (alu_res == '0);
        neg_op            <= alu_res[DATA_W-1];
        unsigned_overflow <= alu_carry;
        signed_overflow   <= alu_sovf;
      end
    end
  end

  assign ram_addr = addr_sel ? ir[ADDR_W-1:0] : pc;
  assign data_out = regs[ir[6:5]];

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - scoreboard bench for datapath with a behavioural reference model

module tb_datapath;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic branch = 0, pc_enable = 0, ir_enable = 0, write_reg_enable = 0;
  logic addr_sel = 0, c_sel = 0, flags_reg_enable = 0;
  logic [1:0]  operation = 2'b00;
  logic [15:0] data_in = '0;
  logic [4:0]  ram_addr;
  logic [15:0] data_out;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;

  datapath #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .write_reg_enable(write_reg_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .flags_reg_enable(flags_reg_enable), .data_in(data_in),
    .ram_addr(ram_addr), .data_out(data_out),
    .decoded_instruction(decoded_instruction), .zero_op(zero_op),
    .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] dout;
    int          dec;
    logic [3:0]  flags;
  } obs_t;

  obs_t exp_q[$];
  int n_vec = 0;
  int n_fail = 0;

  // Reference state
  int          m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_regs [4];
  logic        m_z, m_n, m_u, m_s;

  function automatic decoded_instruction_type ref_decode(input logic [15:0] ir);
    logic [7:0] op;
    op = ir[15:8];
    case (op)
      8'hFF: return I_HALT;
      8'h81: return I_LOAD;
      8'h82: return I_STORE;
      8'h91: return I_MOVE;
      8'hA1: return I_ADD;
      8'hA2: return I_SUB;
      8'hA3: return I_AND;
      8'hA4: return I_OR;
      8'h01: return I_BRANCH;
      8'h02: return I_BZERO;
      8'h03: return I_BNZERO;
      8'h04: return I_BNEG;
      8'h05: return I_BNNEG;
      8'h06: return I_BOV;
      8'h07: return I_BNOV;
      default: return I_NOP;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ir = '0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_z = 0; m_n = 0; m_u = 0; m_s = 0;
  endtask

  // One clock cycle: apply inputs, queue expected outputs, advance the model.
  task automatic step(input bit r, input bit br, input bit pe, input bit ie,
                      input bit we, input bit as, input bit cs, input bit fe,
                      input logic [1:0] op, input logic [15:0] din);
    obs_t o;
    decoded_instruction_type d;
    logic [15:0] a, b, res;
    int s, dest;
    bit carry, sovf;
    @(posedge clk);
    #1;
    rst = r; branch = br; pc_enable = pe; ir_enable = ie;
    write_reg_enable = we; addr_sel = as; c_sel = cs; flags_reg_enable = fe;
    operation = op; data_in = din;
    if (r) model_reset();
    d = ref_decode(m_ir);
    o.addr  = as ? m_ir[4:0] : 5'(m_pc);
    o.dout  = m_regs[m_ir[6:5]];
    o.dec   = int'(d);
    o.flags = {m_z, m_n, m_u, m_s};
    exp_q.push_back(o);
    if (!r) begin
      if (d == I_MOVE) begin a = m_regs[m_ir[1:0]]; b = 16'h0; end
      else begin a = m_regs[m_ir[3:2]]; b = m_regs[m_ir[1:0]]; end
      carry = 0; sovf = 0;
      case (op)
        2'd0: res = a | b;
        2'd1: begin
          s = int'(a) + int'(b); res = 16'(s); carry = (s > 65535);
          sovf = (a[15] == b[15]) && (res[15] != a[15]);
        end
        2'd2: begin
          s = int'(a) - int'(b); res = 16'(s); carry = (s < 0);
          sovf = (a[15] != b[15]) && (res[15] != a[15]);
        end
        default: res = a & b;
      endcase
      if (we && (d inside {I_LOAD, I_MOVE, I_ADD, I_SUB, I_AND, I_OR})) begin
        dest = (d == I_LOAD) ? int'(m_ir[6:5]) : (d == I_MOVE) ? int'(m_ir[3:2]) : int'(m_ir[5:4]);
        m_regs[dest] = cs ? res : din;
      end
      if (fe) begin
        m_z = (res == 16'h0); m_n = res[15]; m_u = carry; m_s = sovf;
      end
      if (pe) m_pc = br ? int'(m_ir[4:0]) : (m_pc + 1) % 32;
      if (ie) m_ir = din;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      chk("ram_addr", int'(ram_addr), int'(e.addr));
      chk("data_out", int'(data_out), int'(e.dout));
      chk("decoded_instruction", int'(decoded_instruction), e.dec);
      chk("flags(z,n,u,s)", int'({zero_op, neg_op, unsigned_overflow, signed_overflow}), int'(e.flags));
    end
  end

  task automatic idle(input bit as);
    step(0, 0, 0, 0, 0, as, 0, 0, 2'd0, 16'h0);
  endtask

  task automatic fetch(input logic [15:0] instr);
    step(0, 0, 1, 1, 0, 0, 0, 0, 2'd0, instr);
  endtask

  task automatic load_reg(input logic [1:0] idx, input logic [15:0] val);
    fetch({8'h81, 1'b0, idx, 5'd5});
    idle(1);
    step(0, 0, 0, 0, 1, 1, 0, 0, 2'd0, val);
  endtask

  task automatic exec(input logic [15:0] instr, input logic [1:0] op, input bit fe);
    fetch(instr);
    step(0, 0, 0, 0, 1, 0, 1, fe, op, 16'h0);
  endtask

  task automatic show(input logic [1:0] idx);
    fetch({8'h82, 1'b0, idx, 5'd3});
    idle(1);
  endtask

  logic [7:0] opcodes [16] = '{8'h00, 8'hFF, 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3,
                               8'hA4, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

  initial begin
    logic [15:0] din;
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 16'h0);

    // PC to 31 by branch, then fetch wraps PC to 0
    fetch(16'h011F);
    step(0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 16'h0);
    idle(0);
    fetch(16'hA11B);
    idle(0);

    // ADD overflow
    load_reg(2, 16'h7FFF);
    load_reg(3, 16'h0001);
    exec(16'hA11B, 2'd1, 1);
    show(1);
    // SUB to zero, then SUB with borrow
    load_reg(2, 16'h1234);
    load_reg(3, 16'h1234);
    exec(16'hA21B, 2'd2, 1);
    show(1);
    load_reg(2, 16'h0000);
    load_reg(3, 16'h0001);
    exec(16'hA21B, 2'd2, 1);
    show(1);
    // LOAD / STORE of r2
    load_reg(2, 16'hBEEF);
    fetch(16'h8245);
    idle(1);
    // MOVE without flag update, then branch to 20
    load_reg(2, 16'h00F0);
    exec(16'h9106, 2'd0, 0);
    show(1);
    fetch(16'h0114);
    step(0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 16'h0);
    idle(0);
    // Write to a non-writing decode (STORE) leaves registers alone
    fetch(16'h8225);
    step(0, 0, 0, 0, 1, 1, 0, 1, 2'd1, 16'h5555);
    idle(1);
    // Reset in the middle of an ALU write, then fetch from 0
    load_reg(1, 16'h4321);
    fetch(16'hA11B);
    step(1, 0, 0, 0, 1, 0, 1, 1, 2'd1, 16'h0);
    fetch(16'h0000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      din = 16'($urandom);
      if ($urandom_range(0, 1) == 1) din[15:8] = opcodes[$urandom_range(0, 15)];
      step($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), din);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expected observations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
